// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: single-outstanding command sequencer between a host
// command/response channel and a multi-cycle ALU.
//   IDLE -> accepts one command, drives it onto alu_a/alu_b/alu_fun
//   WAIT -> holds the ALU inputs for ALU_LAT edges, then captures the result
//   RESP -> presents the captured result until the host takes it
// Optional feature, enabled by defining ALU_SEQ_DIV0_CHECK_EN: a divide
// (function 0011) by zero is never sent to the ALU and is answered directly
// with an error response.
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_fun,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_fun,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_arith,
  input  logic        alu_logic,
  input  logic        alu_cmp,
  input  logic        alu_shift,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic [3:0]  rsp_fun,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  localparam logic [3:0] FUN_NOP = 4'b1111;
  localparam logic [3:0] LAT_W   = 4'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        cmd_hs;
  logic        rsp_hs;
  logic        capture;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign capture   = (state_q == S_WAIT) && (cnt_q == 4'd1);

`ifdef ALU_SEQ_DIV0_CHECK_EN
  localparam logic [3:0] FUN_DIV = 4'b0011;
  logic div0;
  assign div0 = (cmd_fun == FUN_DIV) && (cmd_b == 16'h0000);
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state decode for the three-state handshake controller.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
`ifdef ALU_SEQ_DIV0_CHECK_EN
          state_d = div0 ? S_RESP : S_WAIT;
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT:  if (capture) state_d = S_RESP;
      S_RESP:  if (rsp_hs)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; synchronous reset drops any in-flight command.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: ALU operand issue, latency counter, response capture, op counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      alu_fun   <= FUN_NOP;
      cnt_q     <= 4'd0;
      rsp_data  <= 16'h0000;
      rsp_flags <= 5'b00000;
      rsp_fun   <= 4'b0000;
      op_count  <= 16'h0000;
`ifdef ALU_SEQ_DIV0_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      if (cmd_hs) begin
        rsp_fun <= cmd_fun;
`ifdef ALU_SEQ_DIV0_CHECK_EN
        if (div0) begin
          // Answered locally: the ALU inputs stay idle.
          rsp_data  <= 16'h0000;
          rsp_flags <= 5'b00000;
          rsp_err   <= 1'b1;
        end else
`endif
        begin
          alu_a   <= cmd_a;
          alu_b   <= cmd_b;
          alu_fun <= cmd_fun;
          cnt_q   <= LAT_W;
        end
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (capture) begin
          rsp_data  <= alu_out;
          rsp_flags <= {alu_shift, alu_cmp, alu_logic, alu_arith, alu_carry};
          alu_fun   <= FUN_NOP;
`ifdef ALU_SEQ_DIV0_CHECK_EN
          rsp_err   <= 1'b0;
`endif
        end
      end
      // Counts consumed responses; wraps naturally at 16 bits.
      if (rsp_hs) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer. Instance dut uses ALU_LAT=1 with
// a combinational ALU model; instance l3 uses ALU_LAT=3 with an ALU model
// whose output is garbage (0xDEAD) until its inputs have been stable long
// enough, so an early capture is visible. Honours ALU_SEQ_DIV0_CHECK_EN.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // ALU_LAT=1 instance signals
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_fun = 4'h0;
  logic [15:0] cmd_a = 16'h0;
  logic [15:0] cmd_b = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [15:0] alu_a, alu_b, alu_out, rsp_data, op_count;
  logic [3:0]  alu_fun, rsp_fun;
  logic [4:0]  alu_flg, rsp_flags;

  // ALU_LAT=3 instance signals
  logic        l3_rst_n = 1'b0;
  logic        l3_cmd_valid = 1'b0;
  logic [3:0]  l3_cmd_fun = 4'h0;
  logic [15:0] l3_cmd_a = 16'h0;
  logic [15:0] l3_cmd_b = 16'h0;
  logic        l3_rsp_ready = 1'b0;
  logic        l3_cmd_ready, l3_rsp_valid, l3_rsp_err;
  logic [15:0] l3_alu_a, l3_alu_b, l3_alu_out, l3_rsp_data, l3_op_count;
  logic [3:0]  l3_alu_fun, l3_rsp_fun;
  logic [4:0]  l3_alu_flg, l3_rsp_flags;
  logic [35:0] l3_last = '1;
  logic [3:0]  l3_age = 4'd0;
  logic [3:0]  l3_stable;
  localparam logic [3:0] L3_READY = 4'd2;

  always #5 clk = ~clk;

  // Bench ALU: {flags[4:0] = shift,cmp,logic,arith,carry ; result[15:0]}
  function automatic logic [20:0] alu_model(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  fl;
    s = 17'h0; r = 16'h0; fl = 5'b0;
    case (f)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; fl = {3'b000, 1'b1, s[16]}; end
      4'h1: begin r = a - b; fl = 5'b00010; end
      4'h2: begin r = a * b; fl = 5'b00010; end
      4'h3: begin r = (b == 16'h0) ? 16'hFFFF : a / b; fl = 5'b00010; end
      4'h4: begin r = a & b; fl = 5'b00100; end
      4'h5: begin r = a | b; fl = 5'b00100; end
      4'h6: begin r = a ^ b; fl = 5'b00100; end
      4'h8: begin r = a << 1; fl = 5'b10000; end
      4'hF: begin r = a; fl = 5'b00000; end
      default: begin r = 16'h0; fl = 5'b00000; end
    endcase
    return {fl, r};
  endfunction

  always_comb {alu_flg, alu_out} = alu_model(alu_fun, alu_a, alu_b);

  // Latency-aware model for the ALU_LAT=3 instance: track stable edges.
  always @(posedge clk) begin
    if ({l3_alu_fun, l3_alu_a, l3_alu_b} !== l3_last) begin
      l3_last <= {l3_alu_fun, l3_alu_a, l3_alu_b};
      l3_age  <= 4'd1;
    end else if (l3_age != 4'd15) begin
      l3_age  <= l3_age + 4'd1;
    end
  end

  always_comb begin
    l3_stable = ({l3_alu_fun, l3_alu_a, l3_alu_b} === l3_last) ? l3_age : 4'd0;
    if (l3_stable >= L3_READY) {l3_alu_flg, l3_alu_out} = alu_model(l3_alu_fun, l3_alu_a, l3_alu_b);
    else                       {l3_alu_flg, l3_alu_out} = {5'b00000, 16'hDEAD};
  end

  alu_cmd_sequencer #(.ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_carry(alu_flg[0]), .alu_arith(alu_flg[1]), .alu_logic(alu_flg[2]),
    .alu_cmp(alu_flg[3]), .alu_shift(alu_flg[4]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_fun(rsp_fun), .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_cmd_sequencer #(.ALU_LAT(3)) l3 (
    .clk(clk), .rst_n(l3_rst_n), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
    .cmd_fun(l3_cmd_fun), .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_fun(l3_alu_fun), .alu_out(l3_alu_out),
    .alu_carry(l3_alu_flg[0]), .alu_arith(l3_alu_flg[1]), .alu_logic(l3_alu_flg[2]),
    .alu_cmp(l3_alu_flg[3]), .alu_shift(l3_alu_flg[4]),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_data(l3_rsp_data),
    .rsp_flags(l3_rsp_flags), .rsp_fun(l3_rsp_fun), .rsp_err(l3_rsp_err), .op_count(l3_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command on dut, wait (bounded) for cmd_ready, pass the handshake edge.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL issue_timeout: cmd_ready=%b wanted 1", cmd_ready); end
    cmd_fun = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; l3_rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_fun = 4'h0; cmd_a = 16'h1111; cmd_b = 16'h2222;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b wanted 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b wanted 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b wanted 0", rsp_err); end
    checks++; if (alu_fun !== 4'hF) begin errors++; $display("FAIL reset_alu_fun: got %h wanted f", alu_fun); end
    checks++; if ({alu_a, alu_b} !== 32'h0) begin errors++; $display("FAIL reset_alu_ab: got %h wanted 0", {alu_a, alu_b}); end
    checks++; if ({rsp_data, rsp_flags, rsp_fun} !== 25'h0) begin errors++; $display("FAIL reset_rsp_regs: got %h wanted 0", {rsp_data, rsp_flags, rsp_fun}); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %h wanted 0", op_count); end
    checks++; if ({l3_cmd_ready, l3_rsp_valid, l3_op_count} !== {2'b10, 16'h0}) begin errors++; $display("FAIL reset_l3: got %h wanted 20000", {l3_cmd_ready, l3_rsp_valid, l3_op_count}); end
    cmd_valid = 1'b0;
    rst_n = 1'b1; l3_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue(4'h0, 16'h0015, 16'h0025);
    checks++; if ({cmd_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL add_wait_state: got ready,valid=%b wanted 00", {cmd_ready, rsp_valid}); end
    checks++; if ({alu_fun, alu_a, alu_b} !== {4'h0, 16'h0015, 16'h0025}) begin errors++; $display("FAIL add_issue: got %h wanted 000150025", {alu_fun, alu_a, alu_b}); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid_latency: got %b wanted 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h003A) begin errors++; $display("FAIL add_rsp_data: got %h wanted 003a", rsp_data); end
    checks++; if (rsp_flags !== 5'b00010) begin errors++; $display("FAIL add_rsp_flags: got %b wanted 00010", rsp_flags); end
    checks++; if ({rsp_fun, rsp_err, alu_fun} !== {4'h0, 1'b0, 4'hF}) begin errors++; $display("FAIL add_resp_misc: got %h wanted 00f", {rsp_fun, rsp_err, alu_fun}); end
    respond();
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count: got %h wanted 0001", op_count); end
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL add_back_idle: got %b wanted 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_backpressure();
    issue(4'h2, 16'd4, 16'd3);
    tick();
    // Offer a different command while the response is pending: must be ignored.
    cmd_valid = 1'b1; cmd_fun = 4'h1; cmd_a = 16'h7777; cmd_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_fun, op_count} !== {2'b10, 16'h000C, 4'h2, 16'd1}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b data=%h fun=%h cnt=%h wanted 1 0 000c 2 0001",
                 i, rsp_valid, cmd_ready, rsp_data, rsp_fun, op_count);
      end
      tick();
    end
    cmd_valid = 1'b0;
    respond();
    checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL backpressure_op_count: got %h wanted 0002", op_count); end
  endtask

  task automatic test_div0();
    issue(4'h3, 16'h0010, 16'h0000);
`ifdef ALU_SEQ_DIV0_CHECK_EN
    checks++; if (alu_fun !== 4'hF) begin errors++; $display("FAIL div0_not_issued: alu_fun=%h wanted f", alu_fun); end
    checks++; if ({rsp_valid, rsp_err, rsp_data, rsp_flags, rsp_fun} !== {2'b11, 16'h0, 5'b0, 4'h3}) begin
      errors++; $display("FAIL div0_err_resp: got %h wanted %h", {rsp_valid, rsp_err, rsp_data, rsp_flags, rsp_fun}, {2'b11, 16'h0, 5'b0, 4'h3}); end
    respond();
    checks++; if (alu_fun !== 4'hF) begin errors++; $display("FAIL div0_after_resp: alu_fun=%h wanted f", alu_fun); end
`else
    checks++; if ({alu_fun, rsp_valid} !== {4'h3, 1'b0}) begin errors++; $display("FAIL div0_issued: got %h wanted 6", {alu_fun, rsp_valid}); end
    tick();
    checks++; if ({rsp_valid, rsp_err, rsp_data, rsp_fun} !== {2'b10, 16'hFFFF, 4'h3}) begin
      errors++; $display("FAIL div0_resp: got %h wanted %h", {rsp_valid, rsp_err, rsp_data, rsp_fun}, {2'b10, 16'hFFFF, 4'h3}); end
    respond();
`endif
    checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL div0_op_count: got %h wanted 0003", op_count); end
  endtask

  task automatic test_noop();
    issue(4'hF, 16'h1234, 16'h5678);
    checks++; if ({alu_fun, alu_a, rsp_valid} !== {4'hF, 16'h1234, 1'b0}) begin errors++; $display("FAIL noop_issued: got %h wanted %h", {alu_fun, alu_a, rsp_valid}, {4'hF, 16'h1234, 1'b0}); end
    tick();
    checks++; if ({rsp_valid, rsp_data, rsp_flags, rsp_fun} !== {1'b1, 16'h1234, 5'b0, 4'hF}) begin
      errors++; $display("FAIL noop_resp: got %h wanted %h", {rsp_valid, rsp_data, rsp_flags, rsp_fun}, {1'b1, 16'h1234, 5'b0, 4'hF}); end
    respond();
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL noop_op_count: got %h wanted 0004", op_count); end
  endtask

  task automatic test_back_to_back();
    int n_cmd, n_rsp, last_hs;
    logic hs, rh;
    n_cmd = 0; n_rsp = 0; last_hs = -1;
    cmd_fun = 4'h6; cmd_a = 16'h00FF; cmd_b = 16'h0F0F; cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
      hs = cmd_valid && cmd_ready;
      rh = rsp_valid && rsp_ready;
      if (rh) begin
        checks++;
        if (rsp_data !== 16'h0FF0) begin errors++; $display("FAIL b2b_data[%0d]: got %h wanted 0ff0", n_rsp, rsp_data); end
        n_rsp++;
      end
      if (hs) begin
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d wanted 3", n_cmd, cyc - last_hs); end
        end
        last_hs = cyc;
        n_cmd++;
      end
      tick();
      if (n_cmd == 4) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (n_rsp != 4) begin errors++; $display("FAIL b2b_rsp_count: got %0d wanted 4", n_rsp); end
    checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL b2b_op_count: got %h wanted 0008", op_count); end
  endtask

  task automatic test_wrap();
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    issue(4'h4, 16'hF0F0, 16'h3C3C);
    tick();
    checks++; if ({rsp_valid, rsp_data, rsp_flags} !== {1'b1, 16'h3030, 5'b00100}) begin errors++; $display("FAIL wrap_and_resp: got %h wanted %h", {rsp_valid, rsp_data, rsp_flags}, {1'b1, 16'h3030, 5'b00100}); end
    respond();
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_op_count: got %h wanted 0000", op_count); end
  endtask

  task automatic test_reset_mid_lat3();
    logic seen;
    l3_cmd_fun = 4'h0; l3_cmd_a = 16'h0015; l3_cmd_b = 16'h0025; l3_cmd_valid = 1'b1;
    tick();
    l3_cmd_valid = 1'b0;
    tick();
    checks++; if ({l3_cmd_ready, l3_rsp_valid, l3_alu_fun} !== {2'b00, 4'h0}) begin errors++; $display("FAIL l3_in_wait: got %h wanted 0", {l3_cmd_ready, l3_rsp_valid, l3_alu_fun}); end
    l3_rst_n = 1'b0;
    tick();
    l3_rst_n = 1'b1;
    checks++; if ({l3_cmd_ready, l3_rsp_valid, l3_alu_fun, l3_op_count} !== {2'b10, 4'hF, 16'h0}) begin
      errors++; $display("FAIL l3_mid_reset: got %h wanted %h", {l3_cmd_ready, l3_rsp_valid, l3_alu_fun, l3_op_count}, {2'b10, 4'hF, 16'h0}); end
    seen = 1'b0;
    l3_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (l3_rsp_valid) seen = 1'b1;
      tick();
    end
    l3_rsp_ready = 1'b0;
    checks++; if (seen !== 1'b0 || l3_op_count !== 16'h0) begin errors++; $display("FAIL l3_no_response: seen=%b op_count=%h wanted 0 0000", seen, l3_op_count); end
    // Full LAT=3 transaction: valid only after the third WAIT edge.
    l3_cmd_valid = 1'b1;
    tick();
    l3_cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (l3_rsp_valid !== 1'b0) begin errors++; $display("FAIL l3_early_valid[%0d]: got %b wanted 0", i, l3_rsp_valid); end
      tick();
    end
    checks++; if (l3_rsp_valid !== 1'b0) begin errors++; $display("FAIL l3_early_valid[2]: got %b wanted 0", l3_rsp_valid); end
    tick();
    checks++; if ({l3_rsp_valid, l3_rsp_data, l3_rsp_flags} !== {1'b1, 16'h003A, 5'b00010}) begin
      errors++; $display("FAIL l3_resp: got %h wanted %h", {l3_rsp_valid, l3_rsp_data, l3_rsp_flags}, {1'b1, 16'h003A, 5'b00010}); end
    l3_rsp_ready = 1'b1;
    tick();
    l3_rsp_ready = 1'b0;
    checks++; if ({l3_cmd_ready, l3_op_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL l3_op_count: got %h wanted 10001", {l3_cmd_ready, l3_op_count}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_div0();
    test_noop();
    test_back_to_back();
    test_wrap();
    test_reset_mid_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
